// File: rtl/rvfi_ill_trap_monitor.sv
// RVFI monitor: checks side effects of retired illegal encodings and that the trap handler
// retires from TRAP_VECTOR within MAX_LATENCY cycles; first violation is latched as a sticky code.
module rvfi_ill_trap_monitor #(
  parameter int unsigned     NRET        = 1,
  parameter int unsigned     XLEN        = 32,
  parameter int unsigned     ILEN        = 32,
  parameter int unsigned     MODE        = 0,
  parameter logic [XLEN-1:0] TRAP_VECTOR = XLEN'(32'h00000010),
  parameter int unsigned     MAX_LATENCY = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     check,
  input  logic [NRET-1:0]          rvfi_valid,
  input  logic [NRET*ILEN-1:0]     rvfi_instruction,
  input  logic [NRET-1:0]          rvfi_trap,
  input  logic [NRET*5-1:0]        rvfi_rd_addr,
  input  logic [NRET*XLEN-1:0]     rvfi_rd_wdata,
  input  logic [NRET*XLEN/8-1:0]   rvfi_mem_wmask,
  input  logic [NRET*XLEN-1:0]     rvfi_pc_rdata,
  output logic                     err,
  output logic [2:0]               err_code,
  output logic [$clog2(NRET):0]    err_channel,
  output logic [15:0]              ill_count,
  output logic                     waiting
);

  localparam int unsigned CHW = $clog2(NRET) + 1;
  localparam int unsigned LW  = $clog2(MAX_LATENCY + 1);
  localparam int unsigned MW  = XLEN / 8;
  localparam logic [LW-1:0] LAT_LAST = LW'(MAX_LATENCY - 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;

  logic [0:0]     state_q, state_d;
  logic [LW-1:0]  lat_q, lat_d;
  logic           err_q, err_d;
  logic [2:0]     code_q, code_d;
  logic [CHW-1:0] chan_q, chan_d;
  logic [15:0]    cnt_q, cnt_d;

  logic [NRET-1:0] ill;
  logic            found, first_ill_seen, first_ill_trap, seen_ill_trap;
  logic            v_found, v_stay, timeout;
  logic [2:0]      cand_code, code_c;
  logic [CHW-1:0]  cand_ch;

  // Out-of-range MODE values fall back to the all-zero-only set.
  function automatic logic is_illegal(input logic [ILEN-1:0] ins);
    logic r;
    r = (ins == '0);
    if (MODE == 1 || MODE == 2) r = r || (ins == '1);
    if (MODE == 2 && ILEN == 32)
      r = r || (ins[6:0] == 7'h6B) || (ins[6:0] == 7'h57) || (ins[6:0] == 7'h77);
    return r;
  endfunction

  always_comb begin
    ill            = '0;
    found          = 1'b0;
    first_ill_seen = 1'b0;
    first_ill_trap = 1'b0;
    seen_ill_trap  = 1'b0;
    v_found        = 1'b0;
    v_stay         = 1'b0;
    cand_code      = 3'd0;
    cand_ch        = '0;
    code_c         = 3'd0;
    for (int unsigned c = 0; c < NRET; c++) begin
      ill[c] = rvfi_valid[c] && is_illegal(rvfi_instruction[c*ILEN +: ILEN]);
      code_c = 3'd0;
      // The lowest valid channel while waiting is the handler entry; its PC check outranks the rest.
      if (state_q == S_WAIT && rvfi_valid[c] && !v_found) begin
        v_found = 1'b1;
        v_stay  = ill[c] && rvfi_trap[c];
        if (rvfi_pc_rdata[c*XLEN +: XLEN] != TRAP_VECTOR) code_c = 3'd6;
      end
      if (code_c == 3'd0 && ill[c]) begin
        if (!rvfi_trap[c])                         code_c = 3'd1;
        else if (rvfi_rd_addr[c*5 +: 5] != '0)     code_c = 3'd2;
        else if (rvfi_rd_wdata[c*XLEN +: XLEN] != '0) code_c = 3'd3;
        else if (rvfi_mem_wmask[c*MW +: MW] != '0) code_c = 3'd4;
      end
      if (code_c == 3'd0 && rvfi_valid[c] && seen_ill_trap) code_c = 3'd5;
      if (ill[c] && !first_ill_seen) begin
        first_ill_seen = 1'b1;
        first_ill_trap = rvfi_trap[c];
      end
      if (ill[c] && rvfi_trap[c]) seen_ill_trap = 1'b1;
      if (code_c != 3'd0 && !found) begin
        found     = 1'b1;
        cand_code = code_c;
        cand_ch   = CHW'(c);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    err_d   = err_q;
    code_d  = code_q;
    chan_d  = chan_q;
    cnt_d   = cnt_q;
    timeout = 1'b0;
    if (!check) begin
      state_d = S_IDLE;
      lat_d   = '0;
    end else begin
      if (|ill && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
      if (state_q == S_IDLE) begin
        if (first_ill_seen && first_ill_trap) begin
          state_d = S_WAIT;
          lat_d   = '0;
        end
      end else if (|rvfi_valid) begin
        state_d = v_stay ? S_WAIT : S_IDLE;
        lat_d   = '0;
      end else if (lat_q == LAT_LAST) begin
        state_d = S_IDLE;
        lat_d   = '0;
        timeout = 1'b1;
      end else begin
        lat_d = lat_q + 1'b1;
      end
      if (!err_q && (found || timeout)) begin
        err_d  = 1'b1;
        code_d = found ? cand_code : 3'd7;
        chan_d = found ? cand_ch : '0;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      lat_q   <= '0;
      err_q   <= 1'b0;
      code_q  <= 3'd0;
      chan_q  <= '0;
      cnt_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      err_q   <= err_d;
      code_q  <= code_d;
      chan_q  <= chan_d;
      cnt_q   <= cnt_d;
    end
  end

  assign err         = err_q;
  assign err_code    = code_q;
  assign err_channel = chan_q;
  assign ill_count   = cnt_q;
  assign waiting     = (state_q == S_WAIT);

endmodule

// File: tb/tb_rvfi_ill_trap_monitor.sv
// Directed plus random bench for rvfi_ill_trap_monitor (NRET=2, MODE=2) against a behavioural model.
module tb_rvfi_ill_trap_monitor;

  localparam int NRET = 2;
  localparam int XLEN = 32;
  localparam int ILEN = 32;

  logic clock = 1'b0;
  logic reset;
  logic chk;

  logic        ch_vld [NRET];
  logic [31:0] ch_ins [NRET];
  logic        ch_trap[NRET];
  logic [4:0]  ch_rd  [NRET];
  logic [31:0] ch_wd  [NRET];
  logic [3:0]  ch_wm  [NRET];
  logic [31:0] ch_pc  [NRET];

  logic [NRET-1:0]        rvfi_valid;
  logic [NRET*ILEN-1:0]   rvfi_instruction;
  logic [NRET-1:0]        rvfi_trap;
  logic [NRET*5-1:0]      rvfi_rd_addr;
  logic [NRET*XLEN-1:0]   rvfi_rd_wdata;
  logic [NRET*XLEN/8-1:0] rvfi_mem_wmask;
  logic [NRET*XLEN-1:0]   rvfi_pc_rdata;

  logic        err;
  logic [2:0]  err_code;
  logic [1:0]  err_channel;
  logic [15:0] ill_count;
  logic        waiting;

  assign rvfi_valid       = {ch_vld[1], ch_vld[0]};
  assign rvfi_instruction = {ch_ins[1], ch_ins[0]};
  assign rvfi_trap        = {ch_trap[1], ch_trap[0]};
  assign rvfi_rd_addr     = {ch_rd[1], ch_rd[0]};
  assign rvfi_rd_wdata    = {ch_wd[1], ch_wd[0]};
  assign rvfi_mem_wmask   = {ch_wm[1], ch_wm[0]};
  assign rvfi_pc_rdata    = {ch_pc[1], ch_pc[0]};

  rvfi_ill_trap_monitor #(
    .NRET(NRET), .XLEN(XLEN), .ILEN(ILEN), .MODE(2),
    .TRAP_VECTOR(32'h00000010), .MAX_LATENCY(16)
  ) dut (
    .clock(clock), .reset(reset), .check(chk),
    .rvfi_valid(rvfi_valid), .rvfi_instruction(rvfi_instruction), .rvfi_trap(rvfi_trap),
    .rvfi_rd_addr(rvfi_rd_addr), .rvfi_rd_wdata(rvfi_rd_wdata), .rvfi_mem_wmask(rvfi_mem_wmask),
    .rvfi_pc_rdata(rvfi_pc_rdata),
    .err(err), .err_code(err_code), .err_channel(err_channel),
    .ill_count(ill_count), .waiting(waiting)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model state
  bit m_wait;
  int m_lat;
  bit m_err;
  int m_code;
  int m_ch;
  int m_cnt;

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    cmp({tag, ".err"},         32'(err),         32'(m_err));
    cmp({tag, ".err_code"},    32'(err_code),    32'(m_code));
    cmp({tag, ".err_channel"}, 32'(err_channel), 32'(m_ch));
    cmp({tag, ".ill_count"},   32'(ill_count),   32'(m_cnt));
    cmp({tag, ".waiting"},     32'(waiting),     32'(m_wait));
  endtask

  function automatic bit ref_ill(input int c);
    logic [31:0] ins;
    ins = ch_ins[c];
    return ch_vld[c] && (ins == 32'h0 || ins == 32'hFFFF_FFFF ||
                         ins[6:0] == 7'h6B || ins[6:0] == 7'h57 || ins[6:0] == 7'h77);
  endfunction

  task automatic model_clear();
    m_wait = 0; m_lat = 0; m_err = 0; m_code = 0; m_ch = 0; m_cnt = 0;
  endtask

  // One clock of the specified behaviour, from the inputs currently applied.
  task automatic model_step();
    bit ill[NRET];
    int v, fi, code, ch;
    bit timeout, any_ill;
    if (!chk) begin
      m_wait = 0;
      m_lat  = 0;
      return;
    end
    v = -1; fi = -1; any_ill = 0; timeout = 0; code = 0; ch = 0;
    for (int c = 0; c < NRET; c++) begin
      ill[c] = ref_ill(c);
      if (ill[c]) any_ill = 1;
      if (ch_vld[c] && v < 0) v = c;
      if (ill[c] && fi < 0) fi = c;
    end
    for (int c = 0; c < NRET && code == 0; c++) begin
      if (m_wait && c == v && ch_pc[c] != 32'h10) code = 6;
      else if (ill[c]) begin
        if (!ch_trap[c])      code = 1;
        else if (ch_rd[c] != 0) code = 2;
        else if (ch_wd[c] != 0) code = 3;
        else if (ch_wm[c] != 0) code = 4;
      end
      if (code == 0 && ch_vld[c])
        for (int i = 0; i < c; i++) if (ill[i] && ch_trap[i]) code = 5;
      if (code != 0) ch = c;
    end
    if (any_ill && m_cnt < 65535) m_cnt++;
    if (!m_wait) begin
      if (fi >= 0 && ch_trap[fi]) begin m_wait = 1; m_lat = 0; end
    end else if (v >= 0) begin
      if (ill[v] && ch_trap[v]) m_lat = 0;
      else m_wait = 0;
    end else if (m_lat == 15) begin
      m_wait = 0; m_lat = 0; timeout = 1;
    end else m_lat++;
    if (!m_err && (code != 0 || timeout)) begin
      m_err  = 1;
      m_code = (code != 0) ? code : 7;
      m_ch   = (code != 0) ? ch : 0;
    end
  endtask

  task automatic idle_inputs();
    for (int c = 0; c < NRET; c++) begin
      ch_vld[c] = 0; ch_ins[c] = 32'h13; ch_trap[c] = 0; ch_rd[c] = 0;
      ch_wd[c] = 0; ch_wm[c] = 0; ch_pc[c] = 32'h10;
    end
  endtask

  task automatic set_ch(input int c, input logic [31:0] ins, input logic trap, input logic [31:0] pc);
    ch_vld[c] = 1; ch_ins[c] = ins; ch_trap[c] = trap; ch_rd[c] = 0;
    ch_wd[c] = 0; ch_wm[c] = 0; ch_pc[c] = pc;
  endtask

  task automatic step(input string tag);
    model_step();
    @(posedge clock);
    #1;
    check_all(tag);
  endtask

  // Called 1 time unit after a rising edge; reset pulse stays clear of the next edge.
  task automatic pulse_reset(input string tag);
    reset = 1;
    #1;
    model_clear();
    check_all(tag);
    #1;
    reset = 0;
  endtask

  initial begin
    reset = 1;
    chk   = 1;
    idle_inputs();
    model_clear();
    repeat (2) @(posedge clock);
    #1;
    check_all("reset");
    reset = 0;

    // Clean illegal trap followed by handler at the vector.
    set_ch(0, 32'h0, 1, 32'h100);
    step("s1_ill");
    cmp("s1_waiting", 32'(waiting), 32'd1);
    idle_inputs();
    set_ch(0, 32'h13, 0, 32'h10);
    step("s1_handler");
    cmp("s1_err", 32'(err), 32'd0);
    cmp("s1_cnt", 32'(ill_count), 32'd1);
    pulse_reset("s1_rst");

    // Illegal without trap.
    idle_inputs();
    set_ch(0, 32'h0, 0, 32'h100);
    step("s2");
    cmp("s2_code", 32'(err_code), 32'd1);
    cmp("s2_chan", 32'(err_channel), 32'd0);
    pulse_reset("s2_rst");

    // Trap must end the retire group.
    idle_inputs();
    set_ch(0, 32'h0, 1, 32'h100);
    set_ch(1, 32'h13, 0, 32'h104);
    step("s3");
    cmp("s3_code", 32'(err_code), 32'd5);
    cmp("s3_chan", 32'(err_channel), 32'd1);
    pulse_reset("s3_rst");

    // Handler retires from the wrong PC.
    idle_inputs();
    set_ch(0, 32'hFFFF_FFFF, 1, 32'h100);
    step("s4_ill");
    idle_inputs();
    set_ch(0, 32'h13, 0, 32'h14);
    step("s4_handler");
    cmp("s4_code", 32'(err_code), 32'd6);
    pulse_reset("s4_rst");

    // Handler never arrives: timeout on the 16th idle cycle.
    idle_inputs();
    set_ch(0, {25'h1234, 7'h57}, 1, 32'h100);
    step("s5_ill");
    idle_inputs();
    for (int i = 1; i <= 16; i++) begin
      step($sformatf("s5_idle%0d", i));
      if (i == 15) cmp("s5_pre_err", 32'(err), 32'd0);
    end
    cmp("s5_code", 32'(err_code), 32'd7);
    cmp("s5_waiting", 32'(waiting), 32'd0);
    pulse_reset("s5_rst");

    // Async reset mid-wait clears everything without an edge.
    set_ch(0, 32'hFFFF_FFFF, 1, 32'h100);
    step("s6_ill");
    idle_inputs();
    step("s6_idle");
    pulse_reset("s6_async");
    cmp("s6_waiting", 32'(waiting), 32'd0);

    // Monitor disabled: no capture, count holds, FSM idle.
    chk = 0;
    set_ch(0, 32'h0, 0, 32'h100);
    step("s7_off");
    cmp("s7_err", 32'(err), 32'd0);
    chk = 1;
    idle_inputs();
    step("s7_on");

    // Randomized traffic with periodic idle windows so timeouts also occur.
    for (int i = 0; i < 600; i++) begin
      logic [31:0] r;
      for (int c = 0; c < NRET; c++) begin
        r = $urandom;
        case ($urandom_range(0, 6))
          0: ch_ins[c] = 32'h0;
          1: ch_ins[c] = 32'hFFFF_FFFF;
          2: ch_ins[c] = {r[31:7], 7'h6B};
          3: ch_ins[c] = {r[31:7], 7'h77};
          4: ch_ins[c] = r;
          default: ch_ins[c] = 32'h13;
        endcase
        ch_vld[c]  = ((i % 70) < 45) && ($urandom_range(0, 2) != 0);
        ch_trap[c] = ($urandom_range(0, 3) != 0);
        ch_rd[c]   = ($urandom_range(0, 5) == 0) ? 5'($urandom) : 5'd0;
        ch_wd[c]   = ($urandom_range(0, 5) == 0) ? $urandom : 32'd0;
        ch_wm[c]   = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'd0;
        ch_pc[c]   = ($urandom_range(0, 4) == 0) ? 32'h14 : 32'h10;
      end
      chk = ($urandom_range(0, 19) != 0);
      step($sformatf("rnd%0d", i));
      if (m_err && $urandom_range(0, 5) == 0) pulse_reset($sformatf("rnd_rst%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
